// File: rtl/stream_dwc_down.sv
`default_nettype none
// ============================================================================
//  Module      : stream_dwc_down
//  Description : AXI-Stream data-width down-converter. Splits each wide input
//                word into IN_WIDTH/OUT_WIDTH narrow beats, LSB slice first,
//                at full throughput. Optional completed-word counter is
//                enabled with the STREAM_DWC_DOWN_STATS_EN macro.
//  Revision    : 1.0 - initial release
// ============================================================================
module stream_dwc_down #(
    parameter int IN_WIDTH  = 64,
    parameter int OUT_WIDTH = 16,
    parameter int CNT_WIDTH = 32
) (
    input  logic                 ap_clk,
    input  logic                 ap_rst_n,
    input  logic [IN_WIDTH-1:0]  in0_V_TDATA,
    input  logic                 in0_V_TVALID,
    output logic                 in0_V_TREADY,
    output logic [OUT_WIDTH-1:0] out_V_TDATA,
    output logic                 out_V_TVALID,
    input  logic                 out_V_TREADY
`ifdef STREAM_DWC_DOWN_STATS_EN
    ,
    output logic [CNT_WIDTH-1:0] xfer_count
`endif
);

    localparam int c_RATIO = IN_WIDTH / OUT_WIDTH;
    localparam int c_IDX_W = (c_RATIO > 1) ? $clog2(c_RATIO) : 1;
    localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(c_RATIO - 1);

    generate
        if ((IN_WIDTH % OUT_WIDTH) != 0 || c_RATIO < 2) begin : g_bad_cfg
            $error("stream_dwc_down: IN_WIDTH must be a multiple of OUT_WIDTH with ratio >= 2");
        end
    endgenerate

    logic [IN_WIDTH-1:0]                   r_buf;
    logic [c_IDX_W-1:0]                    r_idx;
    logic                                  r_full;   // state bit: 0 = EMPTY, 1 = DRAIN
    logic [c_RATIO-1:0][OUT_WIDTH-1:0]     w_slices;
    logic                                  w_last;
    logic                                  w_out_hs;
    logic                                  w_accept;

    assign w_slices     = r_buf;
    assign w_last       = r_full && (r_idx == c_LAST_IDX);
    assign w_out_hs     = r_full && out_V_TREADY;
    assign in0_V_TREADY = ap_rst_n && (!r_full || (w_last && out_V_TREADY));
    assign w_accept     = in0_V_TVALID && in0_V_TREADY;

    assign out_V_TVALID = r_full;
    assign out_V_TDATA  = w_slices[r_idx];

    // A reload on the last slice keeps r_full set, so words stream back-to-back.
    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            r_buf  <= '0;
            r_idx  <= '0;
            r_full <= 1'b0;
        end else if (w_accept) begin
            r_buf  <= in0_V_TDATA;
            r_idx  <= '0;
            r_full <= 1'b1;
        end else if (w_out_hs) begin
            if (w_last) begin
                r_full <= 1'b0;
                r_idx  <= '0;
            end else begin
                r_idx  <= r_idx + 1'b1;
            end
        end
    end

`ifdef STREAM_DWC_DOWN_STATS_EN
    logic [CNT_WIDTH-1:0] r_xfer_count;

    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            r_xfer_count <= '0;
        end else if (w_out_hs && w_last) begin
            r_xfer_count <= r_xfer_count + 1'b1;
        end
    end

    assign xfer_count = r_xfer_count;
`endif

endmodule
`default_nettype wire
